// File: rtl/replay_sampler.sv
// Replay-buffer index sampler.
// Draws random indices below the latched fill level, reads one buffer entry per
// accepted index and hands it to the consumer over a valid/ready handshake,
// repeating until the requested batch length has been delivered.
// Optional feature macro: SAMPLER_DEDUP_EN -- when defined, an index equal to the
// previous accepted index of the same batch is treated as a rejected draw.
//
// state | meaning
// IDLE  | waiting for start; latches batch length and fill level
// DRAW  | test rnd candidate against fill level, retry or accept
// READ  | mem_re high for one cycle at the registered address
// WAIT  | read data returns; captured into out_data
// OUT   | out_valid held until the consumer accepts
// DONE  | one-cycle done pulse, then back to IDLE
module replay_sampler #(
    parameter int NBITS     = 16,
    parameter int ADDR_W    = 10,
    parameter int DATA_W    = 128,
    parameter int BATCH_W   = 6,
    parameter int MAX_RETRY = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NBITS-1:0]    rnd,
    input  logic [ADDR_W:0]     fill_count,
    input  logic                start,
    input  logic [BATCH_W-1:0]  batch_len,
    output logic                mem_re,
    output logic [ADDR_W-1:0]   mem_addr,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic [DATA_W-1:0]   out_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                busy,
    output logic                done,
    output logic                err
);

    localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        DRAW = 3'd1,
        READ = 3'd2,
        WAIT = 3'd3,
        OUT  = 3'd4,
        DONE = 3'd5
    } state_t;

    state_t              state_q, state_d;
    logic [BATCH_W-1:0]  n_req_q, n_req_d;
    logic [ADDR_W:0]     n_fill_q, n_fill_d;
    logic [BATCH_W-1:0]  cnt_q, cnt_d;
    logic [RW-1:0]       retry_q, retry_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                re_q, re_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                valid_q, valid_d;
    logic                err_q, err_d;

    logic [ADDR_W-1:0]   cand;
    logic [ADDR_W:0]     fb_mask;
    logic [ADDR_W-1:0]   fb_idx;
    logic                in_range;
    logic                dup;
    logic                reject;
    logic                retry_max;
    logic [BATCH_W-1:0]  cnt_inc;
    logic                unused_bits;

`ifdef SAMPLER_DEDUP_EN
    logic [ADDR_W-1:0]   prev_q, prev_d;
    logic                prev_vld_q, prev_vld_d;

    // A repeat of the last accepted index is rejected, unless only one entry exists.
    assign dup = prev_vld_q && (cand == prev_q) && (n_fill_q != {{ADDR_W{1'b0}}, 1'b1});
`else
    assign dup = 1'b0;
`endif

    assign cand        = rnd[ADDR_W-1:0];
    assign in_range    = ({1'b0, cand} < n_fill_q);
    assign fb_mask     = n_fill_q - 1'b1;
    assign fb_idx      = cand & fb_mask[ADDR_W-1:0];
    assign reject      = !in_range || dup;
    assign retry_max   = (retry_q == RW'(MAX_RETRY));
    assign cnt_inc     = cnt_q + 1'b1;
    assign unused_bits = ^{rnd, fb_mask};

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            n_req_q  <= '0;
            n_fill_q <= '0;
            cnt_q    <= '0;
            retry_q  <= '0;
            addr_q   <= '0;
            re_q     <= 1'b0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            n_req_q  <= n_req_d;
            n_fill_q <= n_fill_d;
            cnt_q    <= cnt_d;
            retry_q  <= retry_d;
            addr_q   <= addr_d;
            re_q     <= re_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
        end
    end

`ifdef SAMPLER_DEDUP_EN
    // Previous accepted index of the current batch.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q     <= '0;
            prev_vld_q <= 1'b0;
        end else begin
            prev_q     <= prev_d;
            prev_vld_q <= prev_vld_d;
        end
    end
`endif

    // Next-state and datapath update logic.
    always_comb begin
        state_d  = state_q;
        n_req_d  = n_req_q;
        n_fill_d = n_fill_q;
        cnt_d    = cnt_q;
        retry_d  = retry_q;
        addr_d   = addr_q;
        re_d     = 1'b0;
        data_d   = data_q;
        valid_d  = valid_q;
        err_d    = err_q;
`ifdef SAMPLER_DEDUP_EN
        prev_d     = prev_q;
        prev_vld_d = prev_vld_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    n_req_d  = batch_len;
                    n_fill_d = fill_count;
                    cnt_d    = '0;
                    retry_d  = '0;
                    err_d    = (fill_count == '0);
`ifdef SAMPLER_DEDUP_EN
                    prev_vld_d = 1'b0;
`endif
                    if ((batch_len == '0) || (fill_count == '0)) begin
                        state_d = DONE;
                    end else begin
                        state_d = DRAW;
                    end
                end
            end
            DRAW: begin
                if (!reject || retry_max) begin
                    // Fallback masks the candidate into range after MAX_RETRY rejections.
                    addr_d  = reject ? fb_idx : cand;
                    re_d    = 1'b1;
                    retry_d = '0;
                    state_d = READ;
`ifdef SAMPLER_DEDUP_EN
                    prev_d     = reject ? fb_idx : cand;
                    prev_vld_d = 1'b1;
`endif
                end else begin
                    retry_d = retry_q + 1'b1;
                end
            end
            READ: begin
                state_d = WAIT;
            end
            WAIT: begin
                data_d  = mem_rdata;
                valid_d = 1'b1;
                state_d = OUT;
            end
            OUT: begin
                if (out_ready) begin
                    valid_d = 1'b0;
                    cnt_d   = cnt_inc;
                    state_d = (cnt_inc == n_req_q) ? DONE : DRAW;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign mem_re    = re_q;
    assign mem_addr  = addr_q;
    assign out_data  = data_q;
    assign out_valid = valid_q;
    assign err       = err_q;
    assign busy      = (state_q != IDLE) && (state_q != DONE);
    assign done      = (state_q == DONE);

endmodule

// File: doc/replay_sampler.md
REPLAY_SAMPLER -- requirements
Module: replay_sampler

Interface
REQ-001 Parameter NBITS, default 16: width of the random word supplied by the upstream lfsr.
REQ-002 Parameter ADDR_W, default 10: replay-buffer address width, giving a depth of 2^ADDR_W; ADDR_W SHALL be <= NBITS.
REQ-003 Parameter DATA_W, default 128: replay-buffer entry width.
REQ-004 Parameter BATCH_W, default 6: width of the batch-length field.
REQ-005 Parameter MAX_RETRY, default 4: number of rejected draws allowed before the fallback index is used.
REQ-006 Ports SHALL be as follows; there is one clock, and reset is synchronous and active-high.
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- rnd  in  NBITS  random word (lfsr q); a new value every cycle
- fill_count  in  ADDR_W+1  number of valid buffer entries
- start  in  1  one-cycle request for a batch
- batch_len  in  BATCH_W  samples requested; sampled with start
- mem_re  out  1  buffer read strobe
- mem_addr  out  ADDR_W  buffer read address
- mem_rdata  in  DATA_W  buffer read data, valid exactly 1 cycle after mem_re
- out_data  out  DATA_W  sampled entry
- out_valid  out  1  out_data valid
- out_ready  in  1  consumer accepts
- busy  out  1  high from IDLE exit until DONE
- done  out  1  one-cycle pulse at batch end
- err  out  1  sticky: start was seen while fill_count==0; cleared by the next accepted start

Function
REQ-007 The FSM SHALL have the states IDLE, DRAW, READ, WAIT, OUT and DONE.
REQ-008 In IDLE, start=1 SHALL latch batch_len and fill_count into internal registers (n_req, n_fill), clear the sample counter, and go to DRAW; start in any other state SHALL be ignored.
REQ-009 In IDLE with start=1, if n_req==0 or fill_count==0 the FSM SHALL go directly to DONE; fill_count==0 SHALL also set err.
REQ-010 In DRAW, the candidate SHALL be cand = rnd[ADDR_W-1:0].
- If cand < n_fill: accept cand.
- Otherwise: increment the retry count and stay in DRAW.
- When the retry count reaches MAX_RETRY: accept cand & (n_fill-1) instead, which is always < n_fill.
REQ-011 On accept, the FSM SHALL register mem_addr, assert mem_re for exactly 1 cycle (the READ state), and clear the retry count.
REQ-012 In WAIT (the cycle after READ), mem_rdata SHALL be captured into out_data and out_valid SHALL be set; the FSM then goes to OUT.
REQ-013 In OUT, out_data and out_valid SHALL hold stable until out_ready=1; on out_valid&&out_ready the sample count SHALL increment and out_valid SHALL clear in the same edge.
- If the count reaches n_req: go to DONE.
- Otherwise: go to DRAW.
REQ-014 In DONE, done SHALL be 1 for one cycle and busy SHALL be 0; the FSM then returns to IDLE.
REQ-015 Minimum latency SHALL be 3 cycles from DRAW entry to out_valid (DRAW, READ, WAIT); throughput SHALL be at most 1 sample per 4 cycles.
REQ-016 Changes to fill_count during a batch SHALL NOT affect that batch (n_fill is latched at start).
REQ-017 Arithmetic: comparisons SHALL be unsigned at ADDR_W+1 bits; n_fill==2^ADDR_W SHALL accept every cand.

Reset
REQ-018 When rst=1 at a clock edge, the block SHALL enter IDLE and clear the following: mem_re, mem_addr, out_valid, out_data, busy, done, err, and all counters.
REQ-019 Reset asserted mid-batch SHALL abandon the batch with no done pulse; out_valid SHALL be 0 in the cycle after the reset edge.

Configuration
REQ-020 Macro SAMPLER_DEDUP_EN:
- Defined: an accepted index equal to the previous accepted index in the same batch SHALL count as a rejection (retry), and the fallback path SHALL also apply to it; dedup SHALL be bypassed when n_fill==1.
- Undefined: no duplicate check, and no previous-index register is built.

Verification
REQ-021 fill_count=100, batch_len=4, rnd always 16'h0005, out_ready=1 -> 4 samples with mem_addr=5, done pulse 1 cycle after the 4th handshake, err=0.
REQ-022 fill_count=8, rnd low bits stream 900,901,902,903,904 -> after 4 rejects mem_addr = 904&7 = 0, issued on the 5th DRAW cycle.
REQ-023 fill_count=0, start -> DONE next cycle, err=1, no mem_re; then fill_count=1 with start -> err clears and mem_addr=0.
REQ-024 out_ready held at 0 for 5 cycles in OUT -> out_data stable, no new mem_re; accepted on the first out_ready=1.
REQ-025 rst=1 asserted in WAIT of the 2nd sample -> next cycle busy=0, out_valid=0, no done pulse; a subsequent start runs a full batch.
REQ-026 With SAMPLER_DEDUP_EN defined, fill_count=16 and rnd low bits 3,3,7 -> addresses 3 then 7; with fill_count=1 -> address 0 every sample, with no retries.
